// File: rtl/stl_pkg.sv
// Shared definitions for the STL serial-TileLink bridge: TL-UL opcodes, status codes,
// packet bit layout and the bridge FSM encoding.
package stl_pkg;

    localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] TL_A_GET              = 3'd4;

    localparam logic [2:0] TL_D_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA  = 3'd1;

    localparam logic [2:0] STATUS_OK      = 3'd0;
    localparam logic [2:0] STATUS_TIMEOUT = 3'd1;
    localparam logic [2:0] STATUS_BADOP   = 3'd2;

    // Packet offsets are also hard-coded in stl_uart_client and the host scripts.
    localparam int PKT_OPCODE_LSB  = 0;
    localparam int PKT_SIZE_LSB    = 8;
    localparam int PKT_MASK_LSB    = 16;
    localparam int PKT_ADDR_LSB    = 32;
    localparam int PKT_DATA_LSB    = 64;
    localparam int RSP_OPCODE_LSB  = 0;
    localparam int RSP_DENIED_BIT  = 3;
    localparam int RSP_CORRUPT_BIT = 4;
    localparam int RSP_STATUS_LSB  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_A_SEND = 2'd1,
        ST_D_WAIT = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic is_legal_opcode(input logic [2:0] opcode);
        return (opcode == TL_A_GET) || (opcode == TL_A_PUT_FULL_DATA) ||
               (opcode == TL_A_PUT_PARTIAL_DATA);
    endfunction

    function automatic logic [127:0] make_response(
        input logic [2:0]  opcode,
        input logic        denied,
        input logic        corrupt,
        input logic [2:0]  status,
        input logic [3:0]  size,
        input logic [31:0] address,
        input logic [63:0] data
    );
        logic [127:0] rsp;
        rsp = '0;
        rsp[RSP_OPCODE_LSB +: 3] = opcode;
        rsp[RSP_DENIED_BIT]      = denied;
        rsp[RSP_CORRUPT_BIT]     = corrupt;
        rsp[RSP_STATUS_LSB +: 3] = status;
        rsp[PKT_SIZE_LSB +: 4]   = size;
        rsp[PKT_ADDR_LSB +: 32]  = address;
        rsp[PKT_DATA_LSB +: 64]  = data;
        return rsp;
    endfunction

endpackage

// File: rtl/stl_watchdog.sv
// D-channel watchdog: counts enabled cycles since the last clear and flags expiry
// once TIMEOUT_CYCLES-1 is reached, holding there until cleared.
module stl_watchdog #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    assign expired = (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/stl_tl_bridge.sv
// Bridges one 128-bit STL request packet to a single-beat TL-UL transaction and
// returns a 128-bit response packet; a watchdog turns a lost D reply into TIMEOUT.
module stl_tl_bridge
    import stl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int SOURCE_ID      = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         packet_valid,
    output logic         packet_ready,
    input  logic [127:0] packet_data,
    output logic         tl_response_valid,
    input  logic         tl_response_ready,
    output logic [127:0] tl_response_data,
    output logic         tl_a_valid,
    input  logic         tl_a_ready,
    output logic [2:0]   tl_a_opcode,
    output logic [2:0]   tl_a_param,
    output logic [3:0]   tl_a_size,
    output logic [3:0]   tl_a_source,
    output logic [31:0]  tl_a_address,
    output logic [7:0]   tl_a_mask,
    output logic [63:0]  tl_a_data,
    output logic         tl_a_corrupt,
    input  logic         tl_d_valid,
    output logic         tl_d_ready,
    input  logic [2:0]   tl_d_opcode,
    input  logic [3:0]   tl_d_size,
    input  logic         tl_d_denied,
    input  logic         tl_d_corrupt,
    input  logic [63:0]  tl_d_data,
    output logic [1:0]   debug_state
);

    state_t state;
    logic   wd_expired;
    logic   unused_inputs;

    assign unused_inputs = ^{packet_data[31:24], packet_data[15:12], packet_data[7:3], tl_d_size};

    // Handshake outputs decode state directly so no input ever reaches an output combinationally.
    assign packet_ready      = (state == ST_IDLE);
    assign tl_a_valid        = (state == ST_A_SEND);
    assign tl_d_ready        = (state == ST_IDLE) || (state == ST_D_WAIT);
    assign tl_response_valid = (state == ST_RESP);
    assign debug_state       = state;
    assign tl_a_param        = 3'd0;
    assign tl_a_corrupt      = 1'b0;
    assign tl_a_source       = 4'(SOURCE_ID);

    stl_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state != ST_D_WAIT),
        .enable (state == ST_D_WAIT),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            tl_a_opcode      <= '0;
            tl_a_size        <= '0;
            tl_a_mask        <= '0;
            tl_a_address     <= '0;
            tl_a_data        <= '0;
            tl_response_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (packet_valid) begin
                        tl_a_opcode  <= packet_data[PKT_OPCODE_LSB +: 3];
                        tl_a_size    <= packet_data[PKT_SIZE_LSB +: 4];
                        tl_a_mask    <= packet_data[PKT_MASK_LSB +: 8];
                        tl_a_address <= packet_data[PKT_ADDR_LSB +: 32];
                        tl_a_data    <= packet_data[PKT_DATA_LSB +: 64];
                        if (is_legal_opcode(packet_data[PKT_OPCODE_LSB +: 3])) begin
                            state <= ST_A_SEND;
                        end else begin
                            tl_response_data <= make_response(3'd0, 1'b0, 1'b0, STATUS_BADOP,
                                packet_data[PKT_SIZE_LSB +: 4], packet_data[PKT_ADDR_LSB +: 32], 64'd0);
                            state <= ST_RESP;
                        end
                    end
                end
                ST_A_SEND: begin
                    if (tl_a_ready) begin
                        state <= ST_D_WAIT;
                    end
                end
                ST_D_WAIT: begin
                    // A D beat arriving on the expiry cycle still wins over the timeout.
                    if (tl_d_valid) begin
                        tl_response_data <= make_response(tl_d_opcode, tl_d_denied, tl_d_corrupt,
                            STATUS_OK, tl_a_size, tl_a_address, tl_d_data);
                        state <= ST_RESP;
                    end else if (wd_expired) begin
                        tl_response_data <= make_response(3'd0, 1'b0, 1'b0, STATUS_TIMEOUT,
                            tl_a_size, tl_a_address, 64'd0);
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (tl_response_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stl_tl_bridge.sv
// Self-checking bench for stl_tl_bridge: table of directed request/reply vectors plus
// hand-written timeout, backpressure and mid-transaction reset sequences.
module tb_stl_tl_bridge;
    import stl_pkg::*;

    typedef struct {
        logic [127:0] packet;
        logic         expect_a;
        logic [2:0]   a_opcode;
        logic [3:0]   a_size;
        logic [7:0]   a_mask;
        logic [31:0]  a_address;
        logic [63:0]  a_data;
        logic [2:0]   d_opcode;
        logic         d_denied;
        logic         d_corrupt;
        logic [63:0]  d_data;
        logic [127:0] response;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         packet_valid;
    logic         packet_ready;
    logic [127:0] packet_data;
    logic         tl_response_valid;
    logic         tl_response_ready;
    logic [127:0] tl_response_data;
    logic         tl_a_valid;
    logic         tl_a_ready;
    logic [2:0]   tl_a_opcode;
    logic [2:0]   tl_a_param;
    logic [3:0]   tl_a_size;
    logic [3:0]   tl_a_source;
    logic [31:0]  tl_a_address;
    logic [7:0]   tl_a_mask;
    logic [63:0]  tl_a_data;
    logic         tl_a_corrupt;
    logic         tl_d_valid;
    logic         tl_d_ready;
    logic [2:0]   tl_d_opcode;
    logic [3:0]   tl_d_size;
    logic         tl_d_denied;
    logic         tl_d_corrupt;
    logic [63:0]  tl_d_data;
    logic [1:0]   debug_state;

    int compared = 0;
    int mismatched = 0;
    int a_handshakes = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    stl_tl_bridge #(
        .TIMEOUT_CYCLES(16),
        .SOURCE_ID(0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .packet_valid(packet_valid), .packet_ready(packet_ready), .packet_data(packet_data),
        .tl_response_valid(tl_response_valid), .tl_response_ready(tl_response_ready),
        .tl_response_data(tl_response_data),
        .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
        .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
        .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
        .tl_a_corrupt(tl_a_corrupt),
        .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
        .tl_d_size(tl_d_size), .tl_d_denied(tl_d_denied), .tl_d_corrupt(tl_d_corrupt),
        .tl_d_data(tl_d_data), .debug_state(debug_state)
    );

    always @(posedge clk) begin
        if (reset_n && tl_a_valid && tl_a_ready) a_handshakes++;
    end

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_packet_ready"}, packet_ready, 1);
        check_output({tag, "_a_valid"}, tl_a_valid, 0);
        check_output({tag, "_resp_valid"}, tl_response_valid, 0);
        check_output({tag, "_d_ready"}, tl_d_ready, 1);
        check_output({tag, "_state"}, debug_state, 0);
        check_output({tag, "_resp_data"}, tl_response_data, 0);
        check_output({tag, "_a_fields"}, {tl_a_opcode, tl_a_param, tl_a_size, tl_a_source,
                     tl_a_address, tl_a_mask, tl_a_data, tl_a_corrupt}, 0);
    endtask

    // Pulse packet_valid for exactly one cycle while the bridge is idle.
    task automatic apply_stimulus(input logic [127:0] pkt);
        @(posedge clk); #1;
        packet_valid = 1'b1;
        packet_data  = pkt;
        @(posedge clk); #1;
        packet_valid = 1'b0;
    endtask

    task automatic drive_d(input logic [2:0] op, input logic denied, input logic corrupt,
                           input logic [63:0] data);
        tl_d_valid   = 1'b1;
        tl_d_opcode  = op;
        tl_d_denied  = denied;
        tl_d_corrupt = corrupt;
        tl_d_size    = 4'd3;
        tl_d_data    = data;
        @(posedge clk); #1;
        tl_d_valid   = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int hs_before;
        string tag;
        tag = $sformatf("vec%0d", idx);
        hs_before = a_handshakes;
        apply_stimulus(v.packet);
        @(negedge clk);
        check_output({tag, "_packet_ready_busy"}, packet_ready, 0);
        if (v.expect_a) begin
            check_output({tag, "_a_valid"}, tl_a_valid, 1);
            check_output({tag, "_a_header"}, {tl_a_opcode, tl_a_param, tl_a_size, tl_a_source,
                         tl_a_corrupt}, {v.a_opcode, 3'd0, v.a_size, 4'd0, 1'b0});
            check_output({tag, "_a_payload"}, {tl_a_address, tl_a_mask, tl_a_data},
                         {v.a_address, v.a_mask, v.a_data});
            @(negedge clk);
            check_output({tag, "_d_wait_state"}, {tl_a_valid, tl_d_ready, debug_state},
                         {1'b0, 1'b1, 2'd2});
            drive_d(v.d_opcode, v.d_denied, v.d_corrupt, v.d_data);
            @(negedge clk);
        end else begin
            check_output({tag, "_no_a_valid"}, tl_a_valid, 0);
        end
        check_output({tag, "_resp_valid"}, tl_response_valid, 1);
        check_output({tag, "_resp_data"}, tl_response_data, v.response);
        check_output({tag, "_a_handshakes"}, a_handshakes - hs_before, v.expect_a ? 1 : 0);
        @(negedge clk);
        check_output({tag, "_back_idle"}, {packet_ready, tl_response_valid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: got no finish, expected finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int cycles;
        int hs_before;
        vecs[0] = '{128'h0000000000000000_80000010_00FF0304, 1'b1, TL_A_GET, 4'd3, 8'hFF,
                    32'h80000010, 64'h0, TL_D_ACCESS_ACK_DATA, 1'b0, 1'b0,
                    64'hDEADBEEF01234567, 128'hDEADBEEF01234567_80000010_00000301};
        vecs[1] = '{128'h1122334455667788_00001000_AA0F53F8, 1'b1, TL_A_PUT_FULL_DATA, 4'd3,
                    8'h0F, 32'h00001000, 64'h1122334455667788, TL_D_ACCESS_ACK, 1'b0, 1'b0,
                    64'h0, 128'h0000000000000000_00001000_00000300};
        vecs[2] = '{128'hCAFEF00D00000000_40000004_00F00201, 1'b1, TL_A_PUT_PARTIAL_DATA, 4'd2,
                    8'hF0, 32'h40000004, 64'hCAFEF00D00000000, TL_D_ACCESS_ACK, 1'b1, 1'b0,
                    64'h0, 128'h0000000000000000_40000004_00000208};
        vecs[3] = '{128'h0000000000000000_00000020_000F0204, 1'b1, TL_A_GET, 4'd2, 8'h0F,
                    32'h00000020, 64'h0, TL_D_ACCESS_ACK_DATA, 1'b1, 1'b1,
                    64'h0123456789ABCDEF, 128'h0123456789ABCDEF_00000020_00000219};
        vecs[4] = '{128'hFFFFFFFFFFFFFFFF_12345678_00330107, 1'b0, 3'd0, 4'd0, 8'h0,
                    32'h0, 64'h0, 3'd0, 1'b0, 1'b0, 64'h0,
                    128'h0000000000000000_12345678_00000140};
        vecs[5] = '{128'h0000000000000000_ABCD0000_00000002, 1'b0, 3'd0, 4'd0, 8'h0,
                    32'h0, 64'h0, 3'd0, 1'b0, 1'b0, 64'h0,
                    128'h0000000000000000_ABCD0000_00000040};

        reset_n = 1'b0; packet_valid = 1'b0; packet_data = '0;
        tl_a_ready = 1'b1; tl_response_ready = 1'b1;
        tl_d_valid = 1'b0; tl_d_opcode = '0; tl_d_size = '0;
        tl_d_denied = 1'b0; tl_d_corrupt = 1'b0; tl_d_data = '0;
        #3;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

        // Timeout: D never answers; response must appear 16 cycles after the A handshake.
        apply_stimulus(128'h0000000000000000_00000040_00FF0304);
        @(negedge clk);
        check_output("to_a_valid", tl_a_valid, 1);
        @(posedge clk);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!tl_response_valid && cycles < 40);
        check_output("to_latency", cycles, 16);
        check_output("to_resp_data", tl_response_data, 128'h0000000000000000_00000040_00000320);
        @(negedge clk);
        check_output("to_idle_d_ready", {debug_state, tl_d_ready}, {2'd0, 1'b1});
        drive_d(TL_D_ACCESS_ACK_DATA, 1'b0, 1'b0, 64'h5555AAAA5555AAAA);
        @(negedge clk);
        check_output("late_d_discarded", {debug_state, tl_response_valid, packet_ready},
                     {2'd0, 1'b0, 1'b1});
        run_vector(vecs[0], 10);

        // Backpressure on both the A channel and the response port.
        hs_before = a_handshakes;
        tl_a_ready = 1'b0;
        tl_response_ready = 1'b0;
        apply_stimulus(vecs[1].packet);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output($sformatf("bp_a_stall%0d", i),
                         {packet_ready, tl_a_valid, tl_a_opcode, tl_a_address, tl_a_mask, tl_a_data},
                         {1'b0, 1'b1, TL_A_PUT_FULL_DATA, 32'h00001000, 8'h0F, 64'h1122334455667788});
        end
        tl_a_ready = 1'b1;
        @(negedge clk);
        check_output("bp_d_wait", debug_state, 2);
        drive_d(TL_D_ACCESS_ACK, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_output($sformatf("bp_resp_stall%0d", i),
                         {packet_ready, tl_response_valid, tl_response_data},
                         {1'b0, 1'b1, 128'h0000000000000000_00001000_00000300});
        end
        tl_response_ready = 1'b1;
        @(negedge clk);
        check_output("bp_back_idle", {packet_ready, tl_response_valid}, 2'b10);
        check_output("bp_single_handshake", a_handshakes - hs_before, 1);

        // Asynchronous reset while waiting for D, then a clean transaction.
        apply_stimulus(vecs[0].packet);
        @(negedge clk);
        @(negedge clk);
        check_output("rst_in_d_wait", debug_state, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        run_vector(vecs[0], 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
